// File: rtl/rst_seq_release_pkg.sv
// Shared state encodings, reset-cause codes and parameter helpers for the reset release sequencer.
package rst_seq_release_pkg;

  typedef enum logic [1:0] {
    ST_SEQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_HW   = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_release_timer.sv
// Loadable down-counter shared by the release and hold phases; saturates at zero.
// expire is high whenever the count is zero; load takes priority over counting.
module rst_seq_timer #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_release.sv
// Releases NUM_STAGES domain resets in order (bit 0 first) with STAGE_DELAY cycles between them;
// a soft request in DONE holds all stages low for SRST_HOLD cycles and re-runs. RST_SEQ_CAUSE_EN adds rst_cause.
module rst_seq_release
  import rst_seq_release_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 16,
  parameter int SRST_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst_req,
  output logic                  srst_ack,
  output logic [NUM_STAGES-1:0] rst_n_stage,
  output logic                  seq_done,
  output logic                  busy
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic [1:0]            rst_cause
`endif
);

  localparam int CNT_W = $clog2(max_int(STAGE_DELAY, SRST_HOLD)) + 1;
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] STAGE_RELOAD = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(SRST_HOLD - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
`ifdef RST_SEQ_CAUSE_EN
  logic [1:0]            cause_q, cause_d;
`endif

  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_val;
  logic                  tmr_expire;

  rst_seq_timer #(
    .W       (CNT_W),
    .RST_VAL (STAGE_RELOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stage_d  = stage_q;
    done_d   = done_q;
    ack_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = STAGE_RELOAD;
`ifdef RST_SEQ_CAUSE_EN
    cause_d  = cause_q;
`endif
    case (state_q)
      ST_SEQ: begin
        if (tmr_expire) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (i == int'(idx_q)) stage_d[i] = 1'b1;
          end
          if (int'(idx_q) == NUM_STAGES - 1) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Level-sensitive: a request still high when we get back here is taken again.
        if (srst_req) begin
          stage_d  = '0;
          done_d   = 1'b0;
          ack_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HOLD_RELOAD;
          state_d  = ST_HOLD;
`ifdef RST_SEQ_CAUSE_EN
          cause_d  = CAUSE_SOFT;
`endif
        end
      end
      ST_HOLD: begin
        if (tmr_expire) begin
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = ST_SEQ;
        end
      end
      default: begin
        state_d = ST_SEQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEQ;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
`ifdef RST_SEQ_CAUSE_EN
      cause_q <= CAUSE_HW;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
`ifdef RST_SEQ_CAUSE_EN
      cause_q <= cause_d;
`endif
    end
  end

  assign rst_n_stage = stage_q;
  assign seq_done    = done_q;
  assign busy        = ~done_q;
  assign srst_ack    = ack_q;
`ifdef RST_SEQ_CAUSE_EN
  assign rst_cause   = cause_q;
`endif

endmodule

// File: doc/rst_seq_release.md
Name: rst_seq_release

Overview:
- Reset release sequencer for the DMA controller subsystem, directly downstream of the 2-FF reset synchronizer.
- Consumes the synchronized active-low reset and releases NUM_STAGES domain resets in fixed order with a programmable gap between them. Intended order: interconnect, then DMA engine, then peripherals.
- Also accepts a soft-reset request from control logic, holds all stages in reset, then re-runs the release sequence.

Parameters:
- NUM_STAGES, 3: number of sequenced reset outputs (1..8).
- STAGE_DELAY, 16: clk cycles between successive stage releases (>=1).
- SRST_HOLD, 8: clk cycles all stages are held low after a soft-reset request (>=1).
- CNT_W: localparam, clog2 of max(STAGE_DELAY, SRST_HOLD) plus 1. Not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset, driven by the synchronizer output (deassertion already synchronous to clk).
- srst_req  in  1  soft-reset request, level, synchronous to clk.
- srst_ack  out  1  one-cycle pulse when a soft request is accepted.
- rst_n_stage  out  NUM_STAGES  per-domain active-low resets; bit 0 releases first.
- seq_done  out  1  high when all stages are released.
- busy  out  1  high while holding or sequencing; equals !seq_done.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rst_n_stage = all 0, seq_done = 0, srst_ack = 0, busy = 1.
  - state = SEQ, stage index = 0, counter = STAGE_DELAY-1.
  - Assertion mid-operation overrides everything immediately.
- All outputs are registered, with no combinational path from inputs to outputs.
- States:
  - SEQ: counter decrements each edge. At counter==0, set rst_n_stage[idx]=1.
    - If idx == NUM_STAGES-1: set seq_done=1 on the same edge and go to DONE.
    - Otherwise: idx++ and reload counter to STAGE_DELAY-1.
  - DONE: all stages high and idle. srst_req is sampled each edge. If it is high:
    - rst_n_stage = all 0, seq_done = 0, srst_ack = 1.
    - Counter = SRST_HOLD-1; go to HOLD.
  - HOLD: srst_ack returns to 0 on the next edge. Counter decrements; at counter==0, idx=0, counter=STAGE_DELAY-1, go to SEQ.
- Timing: edge 1 is the first rising edge with rst_n high. Stage k is released at edge (k+1)*STAGE_DELAY.
- Soft-reset timing: if the request is accepted at edge E, stage k is released at edge E+SRST_HOLD+(k+1)*STAGE_DELAY.
- srst_req in SEQ or HOLD is ignored and not queued. A request still high on return to DONE is accepted again (level semantics).
- Release is monotonic: within a sequence, no stage bit falls except on soft accept or rst_n.
- Invariant: rst_n_stage[j] high implies rst_n_stage[i] high for all i<j.
- STAGE_DELAY=1 releases one stage per edge. NUM_STAGES=1 asserts seq_done at edge STAGE_DELAY.

Optional Feature:
- Macro: RST_SEQ_CAUSE_EN.
- When defined, add output rst_cause (2 bits), registered:
  - 2'b01 after hardware reset.
  - 2'b10 set on the soft-accept edge.
  - Held until the next cause; reset value 2'b01.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared include rst_seq_defs.vh:
  - State encodings ST_SEQ, ST_HOLD, ST_DONE (2-bit).
  - Cause codes CAUSE_HW, CAUSE_SOFT.
- One natural sub-module: rst_seq_timer.
  - Loadable CNT_W down-counter with load and load_val inputs and an expire output (counter==0).
  - Instantiated once and shared by SEQ and HOLD.

Test Plan (NUM_STAGES=3, STAGE_DELAY=4, SRST_HOLD=2):
- Power-on: rst_n low 5 cycles, then high at edge 0 -> rst_n_stage 000 until edge 3; 001 at edge 4, 011 at edge 8, 111 plus seq_done=1 at edge 12; busy=0 from edge 12.
- Soft reset: in DONE, srst_req=1 for 1 cycle sampled at edge E -> at E: stages 000, srst_ack=1; at E+1: ack=0. Stages 001 at E+6, 011 at E+10, 111 at E+14.
- Ignored request: srst_req=1 at edge 6 during SEQ, low by edge 12 -> no ack; sequence identical to power-on.
- Async reset mid-sequence: rst_n low between edges 9 and 10 (stages 011) -> stages 000 immediately, with no clock needed. After release, timing restarts per the power-on case.
- Held request: srst_req stuck high -> ack every 2+12+1=15 cycles. stage[2] is high for 1 cycle per loop; the invariant is never violated.
- RST_SEQ_CAUSE_EN defined: after power-on rst_cause=01; after soft accept it is 10; after a subsequent rst_n pulse it is 01.
